// File: rtl/req_arbiter3.sv
// Three-requester arbiter: registered one-hot grant, bounded tenure, one idle cycle per handoff.
// Define ROUND_ROBIN_EN for rotating priority; fixed priority (req[0] highest) otherwise.
module req_arbiter3 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic [7:0] hold_cnt,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t     state;
  logic [2:0] mask;
  logic [2:0] cand;
  logic [1:0] win;

  // A timed-out holder is masked once, but never starves an otherwise idle bus.
  always_comb begin
    cand = req & ~mask;
    if (cand == 3'b000) cand = req;
  end

`ifdef ROUND_ROBIN_EN
  logic [1:0] last_id;
  logic [1:0] start;
  logic [2:0] rot;
  logic [1:0] k;
  logic [2:0] sum;

  always_comb begin
    start = 2'd0;
    rot   = cand;
    unique case (last_id)
      2'd0: begin
        start = 2'd1;
        rot   = {cand[0], cand[2], cand[1]};
      end
      2'd1: begin
        start = 2'd2;
        rot   = {cand[1], cand[0], cand[2]};
      end
      default: begin
        start = 2'd0;
        rot   = cand;
      end
    endcase
    k = 2'd0;
    priority case (1'b1)
      rot[0]:  k = 2'd0;
      rot[1]:  k = 2'd1;
      rot[2]:  k = 2'd2;
      default: k = 2'd0;
    endcase
    sum = {1'b0, start} + {1'b0, k};
    win = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end
`else
  always_comb begin
    win = 2'd0;
    priority case (1'b1)
      cand[0]: win = 2'd0;
      cand[1]: win = 2'd1;
      cand[2]: win = 2'd2;
      default: win = 2'd0;
    endcase
  end
`endif

  assign gnt_valid = |gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      gnt_id   <= 2'd0;
      hold_cnt <= 8'd0;
      timeout  <= 1'b0;
      mask     <= 3'b000;
`ifdef ROUND_ROBIN_EN
      last_id  <= 2'd2;
`endif
    end else begin
      unique case (state)
        IDLE, GAP: begin
          timeout <= 1'b0;
          if (req == 3'b000) begin
            state    <= IDLE;
            gnt      <= 3'b000;
            gnt_id   <= 2'd0;
            hold_cnt <= 8'd0;
            mask     <= 3'b000;
          end else begin
            state    <= GRANT;
            gnt      <= 3'b001 << win;
            gnt_id   <= win;
            hold_cnt <= 8'd1;
            mask     <= 3'b000;
`ifdef ROUND_ROBIN_EN
            last_id  <= win;
`endif
          end
        end
        GRANT: begin
          if (!req[gnt_id]) begin
            state    <= GAP;
            gnt      <= 3'b000;
            gnt_id   <= 2'd0;
            hold_cnt <= 8'd0;
            timeout  <= 1'b0;
          end else if (hold_cnt == 8'(MAX_HOLD)) begin
            state    <= GAP;
            gnt      <= 3'b000;
            gnt_id   <= 2'd0;
            hold_cnt <= 8'd0;
            timeout  <= 1'b1;
            mask     <= 3'b001 << gnt_id;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter3.sv
// Bench for req_arbiter3: directed plan steps plus random requests
// checked each cycle against a tenure-level model of the arbiter.
module tb_req_arbiter3;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [7:0] hold_cnt;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // model: who owns the resource, for how long, who is barred once
  int       owner;
  int       held;
  bit       to;
  bit [2:0] barred;
  int       last;

  req_arbiter3 #(.MAX_HOLD(MH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id),
    .hold_cnt(hold_cnt),
    .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    owner  = -1;
    held   = 0;
    to     = 1'b0;
    barred = 3'b000;
    last   = 2;
  endfunction

  function automatic int pick(input bit [2:0] r);
    bit [2:0] c;
    int       idx;
    c = r & ~barred;
    if (c == 3'b000) c = r;
`ifdef ROUND_ROBIN_EN
    for (int s = 1; s <= 3; s++) begin
      idx = (last + s) % 3;
      if (c[idx]) return idx;
    end
`else
    for (int s = 0; s < 3; s++) begin
      idx = s;
      if (c[idx]) return idx;
    end
`endif
    return 0;
  endfunction

  function automatic void model_step(input bit [2:0] r);
    if (owner >= 0) begin
      if (!r[owner]) begin
        owner = -1;
        held  = 0;
        to    = 1'b0;
      end else if (held == MH) begin
        barred        = 3'b000;
        barred[owner] = 1'b1;
        owner         = -1;
        held          = 0;
        to            = 1'b1;
      end else begin
        held++;
      end
    end else begin
      to = 1'b0;
      barred = (r == 3'b000) ? 3'b000 : barred;
      if (r != 3'b000) begin
        owner  = pick(r);
        held   = 1;
        last   = owner;
        barred = 3'b000;
      end
    end
  endfunction

  function automatic logic [2:0] exp_gnt();
    return (owner >= 0) ? 3'(1 << owner) : 3'b000;
  endfunction

  task automatic check_all(input string tag);
    logic [2:0] eg;
    logic [1:0] eid;
    eg  = exp_gnt();
    eid = (owner >= 0) ? 2'(owner) : 2'd0;
    checks++;
    assert (gnt === eg) else begin
      errors++;
      $error("FAIL %s gnt: got %b want %b", tag, gnt, eg);
    end
    checks++;
    assert (gnt_valid === (owner >= 0)) else begin
      errors++;
      $error("FAIL %s gnt_valid: got %b want %b", tag, gnt_valid, owner >= 0);
    end
    checks++;
    assert (gnt_id === eid) else begin
      errors++;
      $error("FAIL %s gnt_id: got %0d want %0d", tag, gnt_id, eid);
    end
    checks++;
    assert (hold_cnt === 8'(held)) else begin
      errors++;
      $error("FAIL %s hold_cnt: got %0d want %0d", tag, hold_cnt, held);
    end
    checks++;
    assert (timeout === to) else begin
      errors++;
      $error("FAIL %s timeout: got %b want %b", tag, timeout, to);
    end
  endtask

  task automatic cycle(input logic [2:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] r;
    rst_n = 1'b0;
    req   = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // fixed/rotating priority and release with one dead cycle
    cycle(3'b000, "idle");
    cycle(3'b110, "pri");
    cycle(3'b110, "pri_hold");
    cycle(3'b100, "release");
    cycle(3'b100, "next");
    cycle(3'b000, "drop");
    cycle(3'b000, "idle2");

    // lone requester hits the limit, then is re-granted
    repeat (11) cycle(3'b001, "timeout");
    cycle(3'b000, "to_drop");
    cycle(3'b000, "to_idle");

    // two requesters alternate on timeouts
    repeat (22) cycle(3'b011, "fair");
    cycle(3'b000, "fair_drop");
    cycle(3'b000, "fair_idle");

    // release on the same edge the limit is reached
    repeat (4) cycle(3'b001, "simul_hold");
    cycle(3'b000, "simul_rel");
    cycle(3'b000, "simul_idle");

    // holder drops for one cycle right after each grant
    repeat (4) begin
      cycle(3'b111, "pulse_gnt");
      cycle(3'b111 & ~exp_gnt(), "pulse_rel");
    end
    cycle(3'b000, "pulse_end");
    cycle(3'b000, "pulse_idle");

    // asynchronous reset in the middle of a tenure
    repeat (3) cycle(3'b111, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
    cycle(3'b111, "post_rst");
    cycle(3'b111, "post_rst2");

    // random requests, changed sparsely so tenures reach the limit
    r = 3'b000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      cycle(r, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
